// File: rtl/pc_gen_ras.sv
// Fetch PC generator with prioritised EX redirect, trap entry, misaligned-target
// detection and a circular return-address stack for return prediction.
module pc_gen_ras #(
  parameter int unsigned          WIDTH        = 32,
  parameter logic [WIDTH-1:0]     RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0]     TRAP_VECTOR  = WIDTH'(32'h0000_0100),
  parameter int unsigned          RAS_DEPTH    = 4,
  localparam int unsigned         PTR_W        = $clog2(RAS_DEPTH),
  localparam int unsigned         CNT_W        = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [1:0]       PCSrc,
  input  logic [WIDTH-1:0] PC_ex,
  input  logic [WIDTH-1:0] ImmOp,
  input  logic [WIDTH-1:0] RegIn,
  input  logic             ras_push,
  input  logic             ras_pop,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PC_plus_4,
  output logic             misaligned,
  output logic [WIDTH-1:0] fault_addr,
  output logic [CNT_W-1:0] ras_count
);

  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_BR   = 2'b01,
    SRC_JALR = 2'b10,
    SRC_TRAP = 2'b11
  } pc_src_e;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] fault_addr_q, fault_addr_d;
  logic             misaligned_q, misaligned_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] target;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] wr_idx;
  logic             is_trap, is_redirect, is_fault;
  logic             ras_en, do_push, do_pop;

  assign pc_inc      = pc_q + WIDTH'(4);
  assign is_trap     = (PCSrc == SRC_TRAP);
  assign is_redirect = (PCSrc == SRC_BR) || (PCSrc == SRC_JALR);
  assign target      = (PCSrc == SRC_JALR) ? ((RegIn + ImmOp) & ~WIDTH'(1))
                                           : (PC_ex + ImmOp);
  assign is_fault    = is_redirect && (target[1:0] != 2'b00);

  // Predecode hints belong to the fetched instruction, which a stall or a flush squashes.
  assign ras_en  = !stall && !is_redirect && !is_trap;
  assign do_push = ras_en && ras_push;
  assign do_pop  = ras_en && ras_pop && (cnt_q != '0);
  assign top_idx = ptr_q - PTR_W'(1);
  assign wr_idx  = do_pop ? top_idx : ptr_q;

  always_comb begin
    pc_d         = pc_inc;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    misaligned_d = 1'b0;
    fault_addr_d = fault_addr_q;
    if (is_trap) begin
      pc_d  = TRAP_VECTOR;
      ptr_d = '0;
      cnt_d = '0;
    end else if (is_redirect) begin
      if (is_fault) begin
        pc_d         = TRAP_VECTOR;
        misaligned_d = 1'b1;
        fault_addr_d = target;
      end else begin
        pc_d = target;
      end
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      if (do_pop) pc_d = ras_q[top_idx];
      // Push together with pop replaces the top in place, so depth is unchanged.
      if (do_push && !do_pop) begin
        ptr_d = ptr_q + PTR_W'(1);
        cnt_d = (cnt_q == CNT_W'(RAS_DEPTH)) ? cnt_q : cnt_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        ptr_d = top_idx;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_VECTOR;
      ptr_q        <= '0;
      cnt_q        <= '0;
      misaligned_q <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      pc_q         <= pc_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      misaligned_q <= misaligned_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  // NOTE: the stack storage has no reset; entries are only read when ras_count says they are valid.
  always_ff @(posedge clk) begin
    if (!rst && do_push) ras_q[wr_idx] <= pc_inc;
  end

  assign PC         = pc_q;
  assign PC_plus_4  = pc_inc;
  assign misaligned = misaligned_q;
  assign fault_addr = fault_addr_q;
  assign ras_count  = cnt_q;

endmodule

// File: tb/tb_pc_gen_ras.sv
// Bench for pc_gen_ras: directed vector table for the corner cases, then
// randomized cycles against a queue-based model of the fetch PC and return stack.
module tb_pc_gen_ras;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0;
  localparam logic [31:0] TV    = 32'h100;

  logic        clk = 1'b0;
  logic        rst, stall, ras_push, ras_pop;
  logic [1:0]  PCSrc;
  logic [31:0] PC_ex, ImmOp, RegIn;
  logic [31:0] PC, PC_plus_4, fault_addr;
  logic        misaligned;
  logic [2:0]  ras_count;

  int total = 0;
  int bad   = 0;

  pc_gen_ras #(.WIDTH(32), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .PCSrc(PCSrc), .PC_ex(PC_ex),
    .ImmOp(ImmOp), .RegIn(RegIn), .ras_push(ras_push), .ras_pop(ras_pop),
    .PC(PC), .PC_plus_4(PC_plus_4), .misaligned(misaligned),
    .fault_addr(fault_addr), .ras_count(ras_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall;
    logic [1:0]  src;
    logic [31:0] pcex, imm, regin;
    logic        push, pop;
    logic [31:0] exp_pc;
    int          exp_cnt;
    logic        exp_mis;
    logic [31:0] exp_fa;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic [1:0] src, logic [31:0] pcex,
                              logic [31:0] imm, logic [31:0] regin, logic pu, logic po,
                              logic [31:0] epc, int ecnt, logic emis, logic [31:0] efa);
    vec_t v;
    v.rst = r; v.stall = s; v.src = src; v.pcex = pcex; v.imm = imm; v.regin = regin;
    v.push = pu; v.pop = po; v.exp_pc = epc; v.exp_cnt = ecnt; v.exp_mis = emis;
    v.exp_fa = efa;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic [1:0] src,
                       input logic [31:0] pcex, input logic [31:0] imm,
                       input logic [31:0] regin, input logic pu, input logic po);
    rst = r; stall = s; PCSrc = src; PC_ex = pcex; ImmOp = imm; RegIn = regin;
    ras_push = pu; ras_pop = po;
  endtask

  task automatic check_all(input string tag, input logic [31:0] epc, input int ecnt,
                           input logic emis, input logic [31:0] efa);
    check({tag, " PC"}, PC, epc);
    check({tag, " PC_plus_4"}, PC_plus_4, epc + 32'd4);
    check({tag, " ras_count"}, 32'(ras_count), 32'(ecnt));
    check({tag, " misaligned"}, 32'(misaligned), 32'(emis));
    check({tag, " fault_addr"}, fault_addr, efa);
  endtask

  // Reference model state: the stack is a queue of return addresses, newest at the back.
  logic [31:0] m_pc, m_fa;
  logic        m_mis;
  logic [31:0] m_ras[$];

  task automatic model_step(input logic r, input logic s, input logic [1:0] src,
                            input logic [31:0] pcex, input logic [31:0] imm,
                            input logic [31:0] regin, input logic pu, input logic po);
    logic [31:0] t, npc;
    if (r) begin
      m_pc = RV; m_mis = 1'b0; m_fa = 32'h0; m_ras.delete();
      return;
    end
    m_mis = 1'b0;
    if (src == 2'b11) begin
      m_pc = TV;
      m_ras.delete();
    end else if (src != 2'b00) begin
      t = (src == 2'b01) ? pcex + imm : (regin + imm) & 32'hFFFF_FFFE;
      if (t % 4 != 0) begin
        m_pc = TV; m_mis = 1'b1; m_fa = t;
      end else begin
        m_pc = t;
      end
    end else if (!s) begin
      npc = m_pc + 32'd4;
      if (po && m_ras.size() > 0) npc = m_ras.pop_back();
      if (pu) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end
      m_pc = npc;
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all("reset", RV, 0, 1'b0, 32'h0);

    //            rst  stl  src    PC_ex  Imm           RegIn        psh  pop   PC            cnt mis fa
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           0, 0, 32'h4,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           0, 0, 32'h8,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           0, 0, 32'hC,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           0, 0, 32'h10,       0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 2'b00, 0, 0,            0,           0, 0, 32'h10,       0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 2'b00, 0, 0,            0,           0, 0, 32'h10,       0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 2'b01, 8, 32'h20,       0,           0, 0, 32'h28,       0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h4,        32'h1001,    0, 0, 32'h1004,     0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b01, 0, 32'h6,        0,           0, 0, TV,           0, 1, 32'h6));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           0, 0, TV + 4,       0, 0, 32'h6));
    vecs.push_back(mk(1, 1, 2'b00, 0, 0,            0,           1, 0, RV,           0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           1, 0, 32'h4,        1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           1, 0, 32'h8,        2, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           1, 0, 32'hC,        3, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           1, 0, 32'h10,       4, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           1, 0, 32'h14,       4, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           0, 1, 32'h14,       3, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           0, 1, 32'h10,       2, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           0, 1, 32'hC,        1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           0, 1, 32'h8,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           0, 1, 32'hC,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b01, 0, 32'h3C,       0,           0, 0, 32'h3C,       0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           1, 0, 32'h40,       1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b01, 0, 32'h80,       0,           0, 0, 32'h80,       1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           1, 1, 32'h40,       1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           0, 1, 32'h84,       0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b01, 0, 32'h200,      0,           1, 0, 32'h200,      0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           0, 1, 32'h204,      0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           1, 0, 32'h208,      1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           1, 0, 32'h20C,      2, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           1, 0, 32'h210,      3, 0, 32'h0));
    vecs.push_back(mk(0, 1, 2'b11, 0, 0,            0,           1, 0, TV,           0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 2'b00, 0, 0,            0,           1, 0, TV,           0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 2'b01, 0, 32'h40,       0,           0, 0, RV,           0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b01, 0, 32'hFFFF_FFFC, 0,          0, 0, 32'hFFFF_FFFC, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           0, 0, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 2'b10, 0, 32'h1,        32'h1001,    0, 0, TV,           0, 1, 32'h1002));
    vecs.push_back(mk(0, 0, 2'b10, 0, 0,            32'h1,       0, 0, 32'h0,        0, 0, 32'h1002));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           1, 0, 32'h4,        1, 0, 32'h1002));
    vecs.push_back(mk(0, 0, 2'b01, 0, 32'h3,        0,           0, 0, TV,           1, 1, 32'h3));
    vecs.push_back(mk(0, 0, 2'b00, 0, 0,            0,           0, 1, 32'h4,        0, 0, 32'h3));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].src, vecs[i].pcex, vecs[i].imm,
            vecs[i].regin, vecs[i].push, vecs[i].pop);
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_cnt,
                vecs[i].exp_mis, vecs[i].exp_fa);
    end

    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    model_step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;

    for (int n = 0; n < 3000; n++) begin
      logic        r, s, pu, po;
      logic [1:0]  src;
      logic [31:0] pcex, imm, regin;
      int unsigned sel;
      r     = ($urandom_range(0, 99) == 0);
      s     = ($urandom_range(0, 3) == 0);
      sel   = $urandom_range(0, 99);
      src   = (sel < 70) ? 2'b00 : (sel < 82) ? 2'b01 : (sel < 94) ? 2'b10 : 2'b11;
      pcex  = $urandom & 32'hFFFF_FFFC;
      imm   = 32'($urandom_range(0, 1023)) * 32'd4;
      if ($urandom_range(0, 7) == 0) imm = imm + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) imm = $urandom;
      regin = $urandom;
      if ($urandom_range(0, 1) == 0) regin = regin & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) regin = regin | 32'h1;
      pu    = ($urandom_range(0, 2) == 0);
      po    = ($urandom_range(0, 2) == 0);
      drive(r, s, src, pcex, imm, regin, pu, po);
      model_step(r, s, src, pcex, imm, regin, pu, po);
      @(posedge clk); #1;
      check("rnd PC", PC, m_pc);
      check("rnd ras_count", 32'(ras_count), 32'(m_ras.size()));
      check("rnd misaligned", 32'(misaligned), 32'(m_mis));
      check("rnd fault_addr", fault_addr, m_fa);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_gen_ras.md
Name: pc_gen_ras

Overview:
- Parametrised successor of the single-cycle program counter, for the pipelined core.
- Generates the fetch PC each cycle with stall and a priority-ordered redirect (branch/jal, jalr, trap).
- Adds a circular return-address stack (RAS) for return prediction and detects misaligned redirect targets.
- Sits at the head of IF; redirects come from EX, RAS push/pop hints come from predecode.

Parameters:
- WIDTH, 32, address/data width.
- RESET_VECTOR, 0, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap or misaligned fault.
- RAS_DEPTH, 4, RAS entries; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stall  in  1  hold PC (IF/ID stalled).
- PCSrc  in  2  EX redirect: 00 none, 01 PC_ex+ImmOp, 10 (RegIn+ImmOp) with bit0 cleared, 11 trap.
- PC_ex  in  WIDTH  PC of the instruction in EX.
- ImmOp  in  WIDTH  immediate offset from EX.
- RegIn  in  WIDTH  rs1 value for jalr.
- ras_push  in  1  fetched instruction is a call; push PC_plus_4.
- ras_pop  in  1  fetched instruction is a return; predict from RAS top.
- PC  out  WIDTH  current fetch PC.
- PC_plus_4  out  WIDTH  PC+4, combinational.
- misaligned  out  1  one-cycle pulse: redirect target bits[1:0] != 0.
- fault_addr  out  WIDTH  offending target; held until the next fault or reset.
- ras_count  out  clog2(RAS_DEPTH)+1  number of valid RAS entries.

Behaviour:
- All state updates on posedge clk. Reset is synchronous and active-high.
- Reset: PC=RESET_VECTOR, misaligned=0, fault_addr=0, ras_count=0, RAS pointer=0. Reset overrides every other input in the same cycle.
- Target computation, WIDTH-bit modulo 2^WIDTH, carry dropped:
  - T01 = PC_ex+ImmOp.
  - T10 = (RegIn+ImmOp) & ~1.
- Next-PC priority, highest first:
  1. rst.
  2. PCSrc=11 -> TRAP_VECTOR.
  3. PCSrc=01/10 with target[1:0]!=0 -> TRAP_VECTOR; misaligned=1 next cycle; fault_addr=target.
  4. PCSrc=01/10 aligned -> target.
  5. stall -> hold PC.
  6. ras_pop with ras_count>0 -> RAS top.
  7. otherwise PC+4.
- Redirects and traps ignore stall (the flush wins).
- misaligned is high for exactly one cycle per fault. It is a registered output, asserted the cycle after the faulting redirect.
- RAS push/pop are ignored when stall=1 or when any redirect or trap is taken that cycle (the wrong-path fetch is squashed).
- RAS push writes PC_plus_4 at the pointer, then pointer++.
  - ras_count saturates at RAS_DEPTH.
  - On overflow the pointer wraps and the oldest entry is overwritten.
- RAS pop reads entry pointer-1, then pointer--, ras_count--.
  - Pop on empty (ras_count=0): no prediction, PC+4, count stays 0, pointer unchanged.
- Push and pop in the same cycle: next PC = current top, the top entry is replaced with PC_plus_4, count unchanged.
- Trap (PCSrc=11) clears the RAS: ras_count=0, pointer=0.
- Branch/jalr redirects and misaligned faults leave RAS contents intact.
- Sequential wrap: PC=FFFF_FFFC -> next PC=0000_0000, no fault.
- Reset mid-stall or mid-redirect: the reset value wins in that cycle.

Test Plan:
- Reset then 3 free-running cycles -> PC 0x0, 0x4, 0x8, 0xC; PC_plus_4 tracks PC+4; ras_count=0.
- PC=0x10, stall=1 for 2 cycles -> PC holds 0x10. Then PCSrc=01, PC_ex=0x8, ImmOp=0x20 with stall still 1 -> PC=0x28 next cycle.
- PCSrc=10, RegIn=0x1001, ImmOp=0x4 -> PC=0x1004 (bit0 cleared). PCSrc=01, PC_ex=0x0, ImmOp=0x6 -> PC=0x100, misaligned pulses one cycle, fault_addr=0x6.
- Push at PCs 0x0, 0x4, 0x8, 0xC, 0x10 (DEPTH=4) -> ras_count=4. Four pops -> PCs 0x14, 0x10, 0xC, 0x8. Fifth pop -> PC+4, count stays 0.
- Same-cycle push+pop with top=0x40 at PC=0x80 -> next PC=0x40, new top=0x84, count unchanged. Push coincident with PCSrc=01 -> push ignored.
- PCSrc=11 with ras_count=3 and stall=1 -> PC=0x100, ras_count=0. Reset asserted together with PCSrc=01 -> PC=RESET_VECTOR.
